// File: rtl/divider_pkg.sv
// Shared types and sign helpers for the sequential divider.
package divider_pkg;

    localparam int unsigned MAX_W  = 64;
    localparam int unsigned MAX_IW = $clog2(MAX_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Two's-complement negation; callers truncate to their own width.
    function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x);
        return ~x + MAX_W'(1);
    endfunction

    // Magnitude of a w-bit two's-complement value held zero-extended in x.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                                 input int unsigned     w);
        return x[MAX_IW'(w - 1)] ? negate(x) : x;
    endfunction

endpackage

// File: rtl/seq_divider_sign_fix.sv
// Applies operand signs to the magnitude quotient/remainder and detects MIN/-1 overflow.
module div_sign_fix
    import divider_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] i_q_mag,
    input  logic [W-1:0] i_r_mag,
    input  logic         i_sign_dvd,
    input  logic         i_sign_dvs,
    input  logic         i_signed_mode,
    output logic [W-1:0] o_quotient_c,
    output logic [W-1:0] o_remainder_c,
    output logic         o_overflow_c
);

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic w_neg_q;
    logic w_neg_r;

    assign w_neg_q = i_signed_mode & (i_sign_dvd ^ i_sign_dvs);
    assign w_neg_r = i_signed_mode & i_sign_dvd;

    assign o_quotient_c  = w_neg_q ? W'(negate(MAX_W'(i_q_mag))) : i_q_mag;
    assign o_remainder_c = w_neg_r ? W'(negate(MAX_W'(i_r_mag))) : i_r_mag;

    // A positive quotient of magnitude 2^(W-1) is only reachable through MIN/-1.
    assign o_overflow_c = i_signed_mode & ~w_neg_q & (i_q_mag == MIN_VAL);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed/unsigned, start/done handshake.
module seq_divider
    import divider_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   signed_mode,
    input  logic [WORD_LENGTH-1:0] dividend,
    input  logic [WORD_LENGTH-1:0] divisor,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] quotient,
    output logic [WORD_LENGTH-1:0] remainder,
    output logic                   div_by_zero,
    output logic                   overflow
);

    localparam int unsigned W     = WORD_LENGTH;
    localparam int unsigned CNT_W = $clog2(WORD_LENGTH + 1);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_signed;
    logic             r_sign_dvd;
    logic             r_sign_dvs;
    logic [W-1:0]     r_dvd_raw;
    logic [W-1:0]     r_dvs_raw;
    logic [W-1:0]     r_dvd;
    logic [W-1:0]     r_dvs_mag;
    logic [W:0]       r_rem;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_quotient;
    logic [W-1:0]     r_remainder;
    logic             r_dbz;
    logic             r_ovf;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [W-1:0]     w_dvd_mag;
    logic [W-1:0]     w_dvs_mag;
    logic [W:0]       w_shift;
    logic [W+1:0]     w_trial;
    logic             w_trial_neg;
    logic             w_dvs_zero;
    logic [W-1:0]     w_fix_q;
    logic [W-1:0]     w_fix_r;
    logic             w_fix_ovf;

    assign w_dvd_mag   = r_signed ? W'(abs_val(MAX_W'(r_dvd_raw), W)) : r_dvd_raw;
    assign w_dvs_mag   = r_signed ? W'(abs_val(MAX_W'(r_dvs_raw), W)) : r_dvs_raw;
    assign w_dvs_zero  = (r_dvs_raw == '0);
    assign w_shift     = {r_rem[W-1:0], r_dvd[W-1]};
    assign w_trial     = {r_rem, r_dvd[W-1]} - {2'b00, r_dvs_mag};
    assign w_trial_neg = w_trial[W+1];

    div_sign_fix #(.W(W)) u_sign_fix (
        .i_q_mag       (r_quo),
        .i_r_mag       (r_rem[W-1:0]),
        .i_sign_dvd    (r_sign_dvd),
        .i_sign_dvs    (r_sign_dvs),
        .i_signed_mode (r_signed),
        .o_quotient_c  (w_fix_q),
        .o_remainder_c (w_fix_r),
        .o_overflow_c  (w_fix_ovf)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = w_dvs_zero ? FIX : CALC;
            CALC:    if (r_cnt == CNT_W'(W - 1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = start ? LOAD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == IDLE) || (w_next == DONE);
            r_busy  <= (w_next == LOAD) || (w_next == CALC) || (w_next == FIX);
            r_done  <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_signed    <= 1'b0;
            r_sign_dvd  <= 1'b0;
            r_sign_dvs  <= 1'b0;
            r_dvd_raw   <= '0;
            r_dvs_raw   <= '0;
            r_dvd       <= '0;
            r_dvs_mag   <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_signed   <= signed_mode;
                        r_sign_dvd <= signed_mode & dividend[W-1];
                        r_sign_dvs <= signed_mode & divisor[W-1];
                        r_dvd_raw  <= dividend;
                        r_dvs_raw  <= divisor;
                    end
                end
                LOAD: begin
                    r_dvd     <= w_dvd_mag;
                    r_dvs_mag <= w_dvs_mag;
                    r_rem     <= '0;
                    r_quo     <= '0;
                    r_cnt     <= '0;
                end
                CALC: begin
                    r_rem <= w_trial_neg ? w_shift : w_trial[W:0];
                    r_dvd <= {r_dvd[W-2:0], 1'b0};
                    r_quo <= {r_quo[W-2:0], ~w_trial_neg};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    if (w_dvs_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dvd_raw;
                        r_dbz       <= 1'b1;
                        r_ovf       <= 1'b0;
                    end else begin
                        r_quotient  <= w_fix_q;
                        r_remainder <= w_fix_r;
                        r_dbz       <= 1'b0;
                        r_ovf       <= w_fix_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready       = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
